// File: rtl/ultrasonic_pkg.sv
// Shared types and constants for the ultrasonic ranging scheduler.
package ultrasonic_pkg;

    localparam int unsigned CLK_HZ           = 12_000_000;
    localparam int unsigned HOLDOFF_60MS_CYC = (CLK_HZ / 1000) * 60;
    localparam int unsigned TIMEOUT_40MS_CYC = (CLK_HZ / 1000) * 40;

    localparam int unsigned SENS_LEFT  = 0;
    localparam int unsigned SENS_FRONT = 1;
    localparam int unsigned SENS_RIGHT = 2;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_WAIT_DONE  = 3'd3,
        ST_SETTLE     = 3'd4,
        ST_HOLDOFF    = 3'd5
    } us_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/us_sched_timer.sv
// Loadable down-counter shared by every timed wait of the scheduler.
// A load of L flags expiry on the L-th cycle after the load edge.
module us_sched_timer #(
    parameter int unsigned TW = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [TW-1:0] load_val_i,
    output logic          expired_c
);

    logic [TW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expiry is the cycle in which the count steps down to zero.
    assign expired_c = (count_q == TW'(1));

endmodule

// File: rtl/ultrasonic_scheduler.sv
// Round-robin HC-SR04 sequencer: pings one channel at a time with start/echo timeouts and holdoff.
// Optional proximity flags near_o are built when NEAR_DETECT_EN is defined.
module ultrasonic_scheduler
    import ultrasonic_pkg::*;
#(
    parameter int unsigned N_SENS      = 3,
    parameter int unsigned DW          = 16,
    parameter int unsigned HOLDOFF_CYC = HOLDOFF_60MS_CYC,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_40MS_CYC,
    parameter int unsigned START_CYC   = 4,
    parameter int unsigned SETTLE_CYC  = 2
`ifdef NEAR_DETECT_EN
   ,parameter int unsigned NEAR_CM     = 8
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [N_SENS-1:0]          ready_i,
    input  logic [N_SENS*DW-1:0]       dist_i,
    output logic [N_SENS-1:0]          measure_o,
    output logic [N_SENS*DW-1:0]       dist_o,
    output logic [N_SENS-1:0]          valid_o,
    output logic [N_SENS-1:0]          fault_o,
`ifdef NEAR_DETECT_EN
    output logic [N_SENS-1:0]          near_o,
`endif
    output logic [$clog2(N_SENS)-1:0]  sel_o,
    output logic                       busy_o
);

    localparam int unsigned SW = $clog2(N_SENS);
    localparam int unsigned TW = $clog2(max_u(HOLDOFF_CYC, TIMEOUT_CYC) + 1);

    us_state_e           state_q, state_d;
    logic [SW-1:0]       sel_q, sel_d;
    logic [N_SENS-1:0]   measure_q, measure_d;
    logic [N_SENS-1:0]   valid_q, valid_d;
    logic [N_SENS-1:0]   fault_q, fault_d;
    logic                busy_q, busy_d;
    logic [DW-1:0]       dist_q [N_SENS];
    logic [DW-1:0]       dist_d [N_SENS];
    logic [DW-1:0]       dist_in [N_SENS];
`ifdef NEAR_DETECT_EN
    logic [N_SENS-1:0]   near_q, near_d;
`endif

    logic                tmr_load;
    logic [TW-1:0]       tmr_val;
    logic                tmr_exp;
    logic                fault_set;
    logic                sample;

    for (genvar g = 0; g < N_SENS; g++) begin : g_chan
        assign dist_in[g]             = dist_i[g*DW +: DW];
        assign dist_o[g*DW +: DW]     = dist_q[g];
    end

    us_sched_timer #(
        .TW (TW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expired_c  (tmr_exp)
    );

    // Sequencing: a not-ready engine is skipped, a silent one is timed out; both mark a fault.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        measure_d = '0;
        valid_d   = '0;
        fault_d   = fault_q;
        dist_d    = dist_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        fault_set = 1'b0;
        sample    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tmr_load = 1'b1;
                if (ready_i[sel_q]) begin
                    measure_d[sel_q] = 1'b1;
                    tmr_val          = TW'(START_CYC);
                    state_d          = ST_WAIT_START;
                end else begin
                    fault_set = 1'b1;
                    tmr_val   = TW'(HOLDOFF_CYC);
                    state_d   = ST_HOLDOFF;
                end
            end
            ST_WAIT_START: begin
                if (!ready_i[sel_q]) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(TIMEOUT_CYC);
                    state_d  = ST_WAIT_DONE;
                end else if (tmr_exp) begin
                    fault_set = 1'b1;
                    tmr_load  = 1'b1;
                    tmr_val   = TW'(HOLDOFF_CYC);
                    state_d   = ST_HOLDOFF;
                end
            end
            ST_WAIT_DONE: begin
                if (ready_i[sel_q]) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(SETTLE_CYC);
                    state_d  = ST_SETTLE;
                end else if (tmr_exp) begin
                    fault_set = 1'b1;
                    tmr_load  = 1'b1;
                    tmr_val   = TW'(HOLDOFF_CYC);
                    state_d   = ST_HOLDOFF;
                end
            end
            ST_SETTLE: begin
                if (tmr_exp) begin
                    sample   = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(HOLDOFF_CYC);
                    state_d  = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (tmr_exp) begin
                    sel_d   = (sel_q == SW'(N_SENS - 1)) ? '0 : sel_q + SW'(1);
                    state_d = en ? ST_ISSUE : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fault_set) begin
            fault_d[sel_q] = 1'b1;
        end
        if (sample) begin
            dist_d[sel_q]  = dist_in[sel_q];
            valid_d[sel_q] = 1'b1;
            fault_d[sel_q] = 1'b0;
        end
        busy_d = (state_d != ST_IDLE);
    end

`ifdef NEAR_DETECT_EN
    always_comb begin
        near_d = near_q;
        if (fault_set) begin
            near_d[sel_q] = 1'b0;
        end
        if (sample) begin
            near_d[sel_q] = (dist_in[sel_q] < DW'(NEAR_CM));
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            measure_q <= '0;
            valid_q   <= '0;
            fault_q   <= '0;
            busy_q    <= 1'b0;
            for (int i = 0; i < N_SENS; i++) begin
                dist_q[i] <= '0;
            end
`ifdef NEAR_DETECT_EN
            near_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            measure_q <= measure_d;
            valid_q   <= valid_d;
            fault_q   <= fault_d;
            busy_q    <= busy_d;
            dist_q    <= dist_d;
`ifdef NEAR_DETECT_EN
            near_q    <= near_d;
`endif
        end
    end

    assign measure_o = measure_q;
    assign valid_o   = valid_q;
    assign fault_o   = fault_q;
    assign sel_o     = sel_q;
    assign busy_o    = busy_q;
`ifdef NEAR_DETECT_EN
    assign near_o    = near_q;
`endif

endmodule
